inst_buffer_r10k: RTL and testbench

- Circular instruction queue between fetch and the R10K back end. It feeds the back end's dispatch_packet, branch_inst, dispatched and branch_haz interface.
- Accepts up to N_WAY fetched instructions per cycle and presents the oldest N_WAY entries, pre-decoded into src1/src2/dest/branch fields.
- Pops the entries the back end reports as dispatched and flushes completely on a branch hazard.

---
 rtl/inst_buffer_r10k_pkg.sv | 37 +++
 rtl/inst_buffer_r10k_if.sv | 35 +++
 rtl/inst_buffer_r10k_dispatch_decode.sv | 42 ++++
 rtl/inst_buffer_r10k.sv | 119 +++++++++++
 tb/tb_inst_buffer_r10k.sv | 259 +++++++++++++++++++++++++
 5 files changed

// File: rtl/inst_buffer_r10k_pkg.sv
// inst_buffer_r10k shared definitions: widths, RV32 opcodes, field
// positions and the dispatch packet handed to the R10K back end.
package inst_buffer_r10k_pkg;

  localparam int XLEN      = 32;
  localparam int N_WAY_DEF = 2;

  localparam int OPC_LSB = 0;
  localparam int OPC_MSB = 6;
  localparam int RD_LSB  = 7;
  localparam int RD_MSB  = 11;
  localparam int RS1_LSB = 15;
  localparam int RS1_MSB = 19;
  localparam int RS2_LSB = 20;
  localparam int RS2_MSB = 24;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

  typedef struct packed {
    logic            valid;
    logic [31:0]     inst;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] npc;
    logic [4:0]      src1;
    logic [4:0]      src2;
    logic [4:0]      dest;
  } DISPATCH_PACKET_R10K;

endpackage

// File: rtl/inst_buffer_r10k_if.sv
// Fetch/dispatch bus of the instruction buffer.
// master: fetch + back end side; slave: the buffer itself.
interface inst_buffer_r10k_if
  import inst_buffer_r10k_pkg::*;
#(
  parameter int N_WAY = N_WAY_DEF,
  parameter int DEPTH = 8
) ();

  logic [N_WAY-1:0]                 if_valid;
  logic [N_WAY-1:0][31:0]           if_inst;
  logic [N_WAY-1:0][XLEN-1:0]       if_pc;
  logic [N_WAY-1:0][XLEN-1:0]       if_npc;
  logic                             if_ready;
  logic [N_WAY-1:0]                 dispatched;
  logic                             branch_haz;
  DISPATCH_PACKET_R10K [N_WAY-1:0]  dispatch_packet;
  logic [N_WAY-1:0]                 branch_inst;
  logic [$clog2(DEPTH):0]           buf_count;

  modport master (
    output if_valid, if_inst, if_pc, if_npc,
    output dispatched, branch_haz,
    input  if_ready, dispatch_packet,
    input  branch_inst, buf_count
  );

  modport slave (
    input  if_valid, if_inst, if_pc, if_npc,
    input  dispatched, branch_haz,
    output if_ready, dispatch_packet,
    output branch_inst, buf_count
  );

endinterface

// File: rtl/inst_buffer_r10k_dispatch_decode.sv
// Per-lane pre-decode: inst_i -> src1_o/src2_o/dest_o register
// indices and is_branch_o (BRANCH, JAL, JALR).
module inst_buffer_r10k_dispatch_decode
  import inst_buffer_r10k_pkg::*;
(
  input  logic [31:0] inst_i,
  output logic [4:0]  src1_o,
  output logic [4:0]  src2_o,
  output logic [4:0]  dest_o,
  output logic        is_branch_o
);

  logic [6:0] op;
  assign op = inst_i[OPC_MSB:OPC_LSB];

  always_comb begin
    src1_o      = inst_i[RS1_MSB:RS1_LSB];
    src2_o      = '0;
    dest_o      = inst_i[RD_MSB:RD_LSB];
    is_branch_o = 1'b0;
    case (op)
      OPC_LUI, OPC_AUIPC: src1_o = '0;
      OPC_JAL: begin
        src1_o      = '0;
        is_branch_o = 1'b1;
      end
      OPC_JALR: is_branch_o = 1'b1;
      OPC_OP: src2_o = inst_i[RS2_MSB:RS2_LSB];
      OPC_BRANCH: begin
        src2_o      = inst_i[RS2_MSB:RS2_LSB];
        dest_o      = '0;
        is_branch_o = 1'b1;
      end
      OPC_STORE: begin
        src2_o = inst_i[RS2_MSB:RS2_LSB];
        dest_o = '0;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/inst_buffer_r10k.sv
// Circular instruction queue between fetch and the R10K dispatch stage.
// Ports: clock, reset (async, active-high), bus (slave: fetch in, dispatch out).
module inst_buffer_r10k
  import inst_buffer_r10k_pkg::*;
#(
  parameter int N_WAY = N_WAY_DEF,
  parameter int DEPTH = 8
) (
  input  logic               clock,
  input  logic               reset,
  inst_buffer_r10k_if.slave  bus
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [DEPTH-1:0][31:0]     inst_q;
  logic [DEPTH-1:0][XLEN-1:0] pc_q;
  logic [DEPTH-1:0][XLEN-1:0] npc_q;

  logic [PW-1:0] head_q, head_d;
  logic [PW-1:0] tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;
  logic [CW-1:0] push_n, pop_n;
  logic          ready;
  logic          run;

  logic [N_WAY-1:0]         lane_v;
  logic [N_WAY-1:0][PW-1:0] lane_idx;
  logic [N_WAY-1:0][4:0]    src1_w, src2_w, dest_w;
  logic [N_WAY-1:0]         br_w;

  // Free space from the registered count only; a same-cycle pop
  // cannot open room for this cycle's group.
  assign ready = (CW'(DEPTH) - count_q) >= CW'(N_WAY);

  always_comb begin
    for (int i = 0; i < N_WAY; i++) begin
      lane_idx[i] = head_q + PW'(i);
      lane_v[i]   = CW'(i) < count_q;
    end
  end

  always_comb begin
    push_n = '0;
    pop_n  = '0;
    run    = 1'b1;
    if (ready) begin
      for (int i = 0; i < N_WAY; i++) begin
        if (bus.if_valid[i]) push_n = push_n + CW'(1);
      end
    end
    // Only the unbroken run of accepted lanes from lane 0 leaves.
    for (int i = 0; i < N_WAY; i++) begin
      if (run && bus.dispatched[i] && lane_v[i]) begin
        pop_n = pop_n + CW'(1);
      end else begin
        run = 1'b0;
      end
    end
    head_d  = head_q + PW'(pop_n);
    tail_d  = tail_q + PW'(push_n);
    count_d = count_q + push_n - pop_n;
    if (bus.branch_haz) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clock) begin
    for (int i = 0; i < N_WAY; i++) begin
      if (CW'(i) < push_n) begin
        inst_q[tail_q + PW'(i)] <= bus.if_inst[i];
        pc_q[tail_q + PW'(i)]   <= bus.if_pc[i];
        npc_q[tail_q + PW'(i)]  <= bus.if_npc[i];
      end
    end
  end

  for (genvar g = 0; g < N_WAY; g++) begin : g_lane
    inst_buffer_r10k_dispatch_decode u_dec (
      .inst_i      (inst_q[lane_idx[g]]),
      .src1_o      (src1_w[g]),
      .src2_o      (src2_w[g]),
      .dest_o      (dest_w[g]),
      .is_branch_o (br_w[g])
    );
  end

  always_comb begin
    for (int i = 0; i < N_WAY; i++) begin
      bus.dispatch_packet[i].valid = lane_v[i];
      bus.dispatch_packet[i].inst  = inst_q[lane_idx[i]];
      bus.dispatch_packet[i].pc    = pc_q[lane_idx[i]];
      bus.dispatch_packet[i].npc   = npc_q[lane_idx[i]];
      bus.dispatch_packet[i].src1  = src1_w[i];
      bus.dispatch_packet[i].src2  = src2_w[i];
      bus.dispatch_packet[i].dest  = dest_w[i];
      bus.branch_inst[i]           = lane_v[i] & br_w[i];
    end
  end

  assign bus.if_ready  = ready;
  assign bus.buf_count = count_q;

endmodule

// File: tb/tb_inst_buffer_r10k.sv
// Bench for inst_buffer_r10k: queue model, per-cycle compare,
// directed corner cases and a randomized phase.
module tb_inst_buffer_r10k;

  typedef struct {
    logic [31:0] inst;
    logic [31:0] pc;
    logic [31:0] npc;
  } ent_t;

  logic clock;
  logic reset;
  int   checks = 0;
  int   errors = 0;
  bit   chk_en = 0;
  ent_t q[$];
  logic [31:0] pc_ctr = 32'h0;

  inst_buffer_r10k_if #(.N_WAY(2), .DEPTH(8)) bif ();

  inst_buffer_r10k #(.N_WAY(2), .DEPTH(8)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bif.slave)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic logic [4:0] e_src1(logic [31:0] x);
    logic [6:0] op;
    op = x[6:0];
    if (op == 7'b0110111 || op == 7'b0010111 || op == 7'b1101111)
      return 5'd0;
    return x[19:15];
  endfunction

  function automatic logic [4:0] e_src2(logic [31:0] x);
    logic [6:0] op;
    op = x[6:0];
    if (op == 7'b0110011 || op == 7'b1100011 || op == 7'b0100011)
      return x[24:20];
    return 5'd0;
  endfunction

  function automatic logic [4:0] e_dest(logic [31:0] x);
    logic [6:0] op;
    op = x[6:0];
    if (op == 7'b1100011 || op == 7'b0100011) return 5'd0;
    return x[11:7];
  endfunction

  function automatic logic e_br(logic [31:0] x);
    logic [6:0] op;
    op = x[6:0];
    return op == 7'b1100011 || op == 7'b1101111 || op == 7'b1100111;
  endfunction

  function automatic logic [31:0] rnd_inst();
    logic [6:0] op;
    case ($urandom_range(0, 8))
      0: op = 7'b0110011;
      1: op = 7'b0010011;
      2: op = 7'b0000011;
      3: op = 7'b0100011;
      4: op = 7'b1100011;
      5: op = 7'b1101111;
      6: op = 7'b1100111;
      7: op = 7'b0110111;
      default: op = 7'b0010111;
    endcase
    return {$urandom_range(0, 32'h1FFFFFF), op};
  endfunction

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Per-cycle comparison against the queue model.
  always @(negedge clock) begin
    if (chk_en && !reset) begin
      chk("buf_count", 64'(bif.buf_count), 64'(q.size()));
      chk("if_ready", 64'(bif.if_ready), 64'((8 - q.size()) >= 2));
      assert (bif.buf_count <= 8);
      for (int i = 0; i < 2; i++) begin
        bit v;
        v = i < q.size();
        chk($sformatf("valid%0d", i),
            64'(bif.dispatch_packet[i].valid), 64'(v));
        chk($sformatf("branch%0d", i), 64'(bif.branch_inst[i]),
            64'(v && e_br(q[i].inst)));
        if (v) begin
          chk($sformatf("inst%0d", i),
              64'(bif.dispatch_packet[i].inst), 64'(q[i].inst));
          chk($sformatf("pc%0d", i),
              64'(bif.dispatch_packet[i].pc), 64'(q[i].pc));
          chk($sformatf("npc%0d", i),
              64'(bif.dispatch_packet[i].npc), 64'(q[i].npc));
          chk($sformatf("src1_%0d", i),
              64'(bif.dispatch_packet[i].src1), 64'(e_src1(q[i].inst)));
          chk($sformatf("src2_%0d", i),
              64'(bif.dispatch_packet[i].src2), 64'(e_src2(q[i].inst)));
          chk($sformatf("dest%0d", i),
              64'(bif.dispatch_packet[i].dest), 64'(e_dest(q[i].inst)));
        end
      end
    end
  end

  // Drive one cycle at posedge+2, apply the queue rules at the edge.
  task automatic step(input logic [1:0] v, input logic [31:0] i0,
                      input logic [31:0] i1, input logic [1:0] d,
                      input logic h);
    int   n;
    bit   rdy;
    ent_t e;
    logic [31:0] ins [2];
    ins[0] = i0;
    ins[1] = i1;
    bif.if_valid   = v;
    bif.dispatched = d;
    bif.branch_haz = h;
    for (int i = 0; i < 2; i++) begin
      bif.if_inst[i] = ins[i];
      bif.if_pc[i]   = pc_ctr + 32'(4 * i);
      bif.if_npc[i]  = pc_ctr + 32'(4 * i + 4);
    end
    assert (v != 2'b10);
    @(posedge clock);
    if (h) begin
      q.delete();
    end else begin
      rdy = (8 - q.size()) >= 2;
      n = 0;
      for (int i = 0; i < 2; i++)
        if (d[i] && i < q.size() && n == i) n++;
      repeat (n) void'(q.pop_front());
      if (rdy) begin
        for (int i = 0; i < 2; i++) begin
          if (v[i]) begin
            e.inst = ins[i];
            e.pc   = pc_ctr + 32'(4 * i);
            e.npc  = pc_ctr + 32'(4 * i + 4);
            q.push_back(e);
          end
        end
      end
    end
    pc_ctr = pc_ctr + 32'd8;
    #2;
  endtask

  initial begin
    logic [31:0] last_pc;
    bit          have;
    logic [1:0]  v, d, m;
    reset          = 1'b1;
    bif.if_valid   = '0;
    bif.if_inst    = '0;
    bif.if_pc      = '0;
    bif.if_npc     = '0;
    bif.dispatched = '0;
    bif.branch_haz = 1'b0;
    repeat (2) @(posedge clock);
    #2;
    chk("rst_count", 64'(bif.buf_count), 64'd0);
    chk("rst_ready", 64'(bif.if_ready), 64'd1);
    chk("rst_valid0", 64'(bif.dispatch_packet[0].valid), 64'd0);
    chk("rst_valid1", 64'(bif.dispatch_packet[1].valid), 64'd0);
    chk("rst_branch", 64'(bif.branch_inst), 64'd0);
    reset  = 1'b0;
    chk_en = 1'b1;

    step(2'b11, 32'h00208033, 32'h00310093, 2'b00, 1'b0);
    chk("add_src1", 64'(bif.dispatch_packet[0].src1), 64'd1);
    chk("add_src2", 64'(bif.dispatch_packet[0].src2), 64'd2);
    chk("add_dest", 64'(bif.dispatch_packet[0].dest), 64'd0);
    chk("addi_src1", 64'(bif.dispatch_packet[1].src1), 64'd2);
    chk("addi_src2", 64'(bif.dispatch_packet[1].src2), 64'd0);
    chk("addi_dest", 64'(bif.dispatch_packet[1].dest), 64'd1);
    chk("pc1_lane0", 64'(bif.dispatch_packet[0].pc), 64'h0);
    chk("count_2", 64'(bif.buf_count), 64'd2);

    repeat (3) step(2'b11, rnd_inst(), rnd_inst(), 2'b00, 1'b0);
    chk("full_count", 64'(bif.buf_count), 64'd8);
    chk("full_ready", 64'(bif.if_ready), 64'd0);
    step(2'b11, rnd_inst(), rnd_inst(), 2'b00, 1'b0);
    chk("full_noacc", 64'(bif.buf_count), 64'd8);

    step(2'b00, 32'h0, 32'h0, 2'b01, 1'b0);
    chk("pop1_count", 64'(bif.buf_count), 64'd7);
    chk("pop1_ready", 64'(bif.if_ready), 64'd0);
    chk("pop1_head", 64'(bif.dispatch_packet[0].pc), 64'h4);
    step(2'b00, 32'h0, 32'h0, 2'b01, 1'b0);
    chk("pop2_ready", 64'(bif.if_ready), 64'd1);
    repeat (3) step(2'b00, 32'h0, 32'h0, 2'b11, 1'b0);
    chk("drain", 64'(bif.buf_count), 64'd0);

    have = 1'b0;
    last_pc = '0;
    for (int c = 0; c < 10; c++) begin
      step(2'b11, rnd_inst(), rnd_inst(),
           (q.size() >= 2) ? 2'b11 : 2'b00, 1'b0);
      if (have)
        chk("pc_order", 64'(bif.dispatch_packet[0].pc > last_pc), 64'd1);
      last_pc = bif.dispatch_packet[0].pc;
      have = 1'b1;
    end

    step(2'b00, 32'h0, 32'h0, 2'b10, 1'b0);
    chk("disp10", 64'(bif.buf_count), 64'd2);
    step(2'b00, 32'h0, 32'h0, 2'b01, 1'b0);
    step(2'b00, 32'h0, 32'h0, 2'b11, 1'b0);
    chk("clamp", 64'(bif.buf_count), 64'd0);

    step(2'b01, 32'h00000063, 32'h0, 2'b00, 1'b0);
    chk("beq_branch", 64'(bif.branch_inst), 64'b01);
    chk("beq_dest", 64'(bif.dispatch_packet[0].dest), 64'd0);
    step(2'b11, rnd_inst(), rnd_inst(), 2'b00, 1'b1);
    chk("flush_count", 64'(bif.buf_count), 64'd0);
    chk("flush_v0", 64'(bif.dispatch_packet[0].valid), 64'd0);
    chk("flush_v1", 64'(bif.dispatch_packet[1].valid), 64'd0);

    step(2'b11, rnd_inst(), rnd_inst(), 2'b00, 1'b0);
    step(2'b11, rnd_inst(), rnd_inst(), 2'b00, 1'b0);
    step(2'b01, rnd_inst(), 32'h0, 2'b00, 1'b0);
    chk("pre_arst", 64'(bif.buf_count), 64'd5);
    #1;
    reset = 1'b1;
    q.delete();
    #1;
    chk("arst_count", 64'(bif.buf_count), 64'd0);
    chk("arst_v0", 64'(bif.dispatch_packet[0].valid), 64'd0);
    chk("arst_v1", 64'(bif.dispatch_packet[1].valid), 64'd0);
    reset = 1'b0;

    for (int c = 0; c < 500; c++) begin
      case ($urandom_range(0, 2))
        0: v = 2'b00;
        1: v = 2'b01;
        default: v = 2'b11;
      endcase
      m = (q.size() >= 2) ? 2'b11 : (q.size() == 1) ? 2'b01 : 2'b00;
      d = 2'($urandom_range(0, 3)) & m;
      step(v, rnd_inst(), rnd_inst(), d, $urandom_range(0, 31) == 0);
    end

    @(negedge clock);
    chk_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
